// File: rtl/data_memory_responder.sv
// Data-memory responder for the MEM stage: one outstanding load/store, served from an
// internal word array after LATENCY cycles, with size/alignment/range error reporting.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAddress,
    input  logic [31:0] ReqWriteData,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    output logic        RespValid,
    output logic [31:0] RespReadData,
    output logic        RespError,
    output logic        Busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           lat_write;
    logic [31:0]    lat_addr;
    logic [31:0]    lat_wdata;
    logic [1:0]     lat_size;
    logic           lat_signed;

    logic [31:0]    mem [DEPTH_WORDS];

    logic [AW-1:0]  idx;
    logic [1:0]     lane;
    logic           range_err;
    logic           align_err;
    logic           req_err;
    logic [31:0]    rd_word;
    logic [7:0]     rd_byte;
    logic [15:0]    rd_half;
    logic [31:0]    load_data;
    logic [3:0]     wr_be;
    logic [31:0]    wr_word;
    logic           access;
    logic           mem_we;

    assign idx       = lat_addr[AW+1:2];
    assign lane      = lat_addr[1:0];
    assign range_err = |lat_addr[31:AW+2];
    assign req_err   = range_err | align_err;
    assign rd_word   = mem[idx];
    assign access    = (state == S_WAIT) && (cnt == '0);
    assign mem_we    = access && lat_write && !req_err;
    assign ReqReady  = Rst && (state == S_IDLE);

    always_comb begin
        align_err = 1'b0;
        case (lat_size)
            2'b01:   align_err = lane[0];
            2'b10:   align_err = |lane;
            2'b11:   align_err = 1'b1;
            default: align_err = 1'b0;
        endcase
    end

    always_comb begin
        rd_byte = rd_word[7:0];
        case (lane)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (lat_size)
            2'b00:   load_data = {{24{lat_signed & rd_byte[7]}}, rd_byte};
            2'b01:   load_data = {{16{lat_signed & rd_half[15]}}, rd_half};
            default: load_data = rd_word;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick the target lane(s).
    always_comb begin
        wr_be   = 4'b1111;
        wr_word = lat_wdata;
        case (lat_size)
            2'b00: begin
                wr_be   = 4'b0001 << lane;
                wr_word = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{lat_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_word = lat_wdata;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[k]) mem[idx][8*k +: 8] <= wr_word[8*k +: 8];
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            lat_write    <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_size     <= '0;
            lat_signed   <= 1'b0;
            RespValid    <= 1'b0;
            RespReadData <= '0;
            RespError    <= 1'b0;
            Busy         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ReqValid) begin
                        lat_write  <= ReqWrite;
                        lat_addr   <= ReqAddress;
                        lat_wdata  <= ReqWriteData;
                        lat_size   <= ReqSize;
                        lat_signed <= ReqSigned;
                        cnt        <= CNT_INIT;
                        Busy       <= 1'b1;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        RespValid    <= 1'b1;
                        RespError    <= req_err;
                        RespReadData <= (!lat_write && !req_err) ? load_data : 32'h0;
                        state        <= S_RESP;
                    end
                end
                S_RESP: begin
                    RespValid <= 1'b0;
                    Busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
Responder side of the MEM-stage data-memory interface: accepts one load/store request at a time from the pipeline's memory stage through a valid/ready handshake. Serves the request from an internal word array after a configurable access latency. Returns read data (extended to 32 bits) or a write acknowledge with an error flag. Replaces the zero-latency combinational data memory so the pipeline can be exercised against realistic multi-cycle memory timing.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two, >= 2
LATENCY, 2, cycles from accept edge to RespValid; integer >= 1

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  asynchronous, active-low reset
ReqValid  input  1  request present
ReqReady  output  1  block can accept a request this cycle
ReqWrite  input  1  1 = store, 0 = load
ReqAddress  input  32  byte address
ReqWriteData  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
ReqSize  input  2  00 byte, 01 half, 10 word, 11 illegal
ReqSigned  input  1  loads only: 1 sign-extend, 0 zero-extend
RespValid  output  1  one-cycle response strobe
RespReadData  output  32  load result; 0 for stores and errors
RespError  output  1  valid with RespValid; misaligned, out-of-range or illegal size
Busy  output  1  request accepted and not yet responded (state != IDLE)

Behaviour:
- Reset (Rst low, asynchronous): state=IDLE; RespValid=0, RespReadData=0, RespError=0, Busy=0, latency counter=0, latched request cleared. ReqReady forced 0 while Rst low. Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: ReqReady=1. On a rising edge with ReqValid=1, latch ReqWrite/ReqAddress/ReqWriteData/ReqSize/ReqSigned. Load counter with LATENCY-1 and go to WAIT. With ReqValid=0, remain in IDLE; request inputs are ignored.
- WAIT: ReqReady=0, Busy=1. While counter != 0, decrement each edge. On the edge where counter==0: perform the access, register the response, go to RESP.
- RESP: RespValid=1 for exactly this one cycle, ReqReady=0. Next edge returns to IDLE; RespValid=0 and RespReadData/RespError hold until the next response.
- Timing: accept at edge N means RespValid is high in the cycle after edge N+LATENCY. The earliest next accept is edge N+LATENCY+2.
- Address decode: word index = ReqAddress[log2(DEPTH_WORDS)+1:2]. Byte lanes are little-endian: lane k = bits [8k+7:8k].
- Error conditions: ReqAddress >= 4*DEPTH_WORDS; size 01 with addr[0]=1; size 10 with addr[1:0]!=0; size 11. On error: RespError=1, RespReadData=0, no array write. The response still completes with normal latency.
- Store: byte writes lane addr[1:0] with data[7:0]; half writes lanes addr[1]*2 and +1 with data[15:0]; word writes all lanes. Other lanes are unchanged. The write commits on the access edge only. Response has RespReadData=0, RespError=0.
- Load: select the lane(s) as for stores, then sign- or zero-extend per the latched ReqSigned. Word loads ignore ReqSigned.
- Load data reflects all stores that responded earlier. Only one request is ever outstanding, so there is no hazard.
- Reset mid-operation (WAIT or RESP): return to IDLE immediately. A store whose access edge has not occurred is dropped. A store already committed stays committed.
- Request inputs changing while Busy have no effect.

Test Plan:
- Reset → ReqReady=0 while Rst low, ReqReady=1 on the first cycle after release, RespValid=0, Busy=0.
- LATENCY=2: store word 0xDEADBEEF @0x10, then load word @0x10 → each RespValid is a single cycle 2 cycles after its accept edge; load returns 0xDEADBEEF, RespError=0.
- Byte/half extension: store word 0x80F17F01 @0x20; load byte @0x23 signed → 0xFFFFFF80, unsigned → 0x00000080; load half @0x22 signed → 0xFFFF80F1; store byte 0xAA @0x21 then load word @0x20 → 0x80F1AA01.
- Errors: load word @0x22, load half @0x25, size 11, load @4*DEPTH_WORDS → RespError=1, RespReadData=0. Store word @0x11 then load @0x10 → memory unchanged.
- Handshake: hold ReqValid=1 continuously with differing payloads → only one accept per LATENCY+2 cycles, and the payload latched is the one present at each accept edge. Busy matches the WAIT/RESP span.
- Reset during WAIT of store 0x12345678 @0x30 (with previous content 0) → state IDLE. A subsequent load @0x30 returns 0x00000000.
